// File: rtl/axi_leg_bridge_pkg.sv
// rtl/axi_leg_bridge_pkg.sv - shared types and default timing for the AXI write to legacy bridge (macro LEGACY_ACK_TIMEOUT_EN)
package axi_leg_bridge_pkg;

    // Legacy write cycle phases; WAIT_ACK only exists when the ack timeout feature is built in
`ifdef LEGACY_ACK_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT_ACK,
        ST_HOLD,
        ST_DONE
    } leg_wr_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } leg_wr_state_e;
`endif

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_LEG_ADDR_W  = 16;
    localparam int unsigned DEF_SETUP_CYC   = 2;
    localparam int unsigned DEF_PULSE_CYC   = 4;
    localparam int unsigned DEF_HOLD_CYC    = 1;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

    // Largest of the four phase lengths; sizes the shared phase counter
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/axi_leg_hold_slot.sv
// rtl/axi_leg_hold_slot.sv - one-entry valid/ready holding register with clear
module axi_leg_hold_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] q
);

    // Capture one beat while empty; clear wins so a consumed entry always frees the slot
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            q    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            q    <= in_data;
        end
    end

    assign in_ready = !full;

endmodule

// File: rtl/axi_wr_to_legacy_bridge.sv
// rtl/axi_wr_to_legacy_bridge.sv - AXI AW/W to timed legacy write cycle bridge (macro LEGACY_ACK_TIMEOUT_EN adds ack wait/timeout)
module axi_wr_to_legacy_bridge
    import axi_leg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned LEG_ADDR_W  = DEF_LEG_ADDR_W,
    parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC   = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    output logic [LEG_ADDR_W-1:0] leg_addr,
    output logic [DATA_W-1:0]     leg_data,
    output logic                  cs_n,
    output logic                  wr_n,
    input  logic                  leg_ack_n,
    output logic                  transaction_complete,
    output logic                  error_detected
);

    localparam int unsigned CNT_W = $clog2(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, TIMEOUT_CYC) + 1);

    if (SETUP_CYC == 0) begin : g_bad_setup
        $error("SETUP_CYC must be at least 1");
    end
    if (PULSE_CYC == 0) begin : g_bad_pulse
        $error("PULSE_CYC must be at least 1");
    end
    if (HOLD_CYC == 0) begin : g_bad_hold
        $error("HOLD_CYC must be at least 1");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    leg_wr_state_e      state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               aw_full, w_full;
    logic [ADDR_W-1:0]  aw_q;
    logic [DATA_W-1:0]  w_q;
    logic               slot_clr;
    logic               load;
    logic               err_nxt;
    logic               addr_bad;
    logic               cs_n_nxt, wr_n_nxt;

`ifndef LEGACY_ACK_TIMEOUT_EN
    logic unused_leg_ack_n;
    assign unused_leg_ack_n = leg_ack_n;
`endif

    axi_leg_hold_slot #(.W(ADDR_W)) u_aw_slot (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .in_valid (awvalid),
        .in_ready (awready),
        .in_data  (awaddr),
        .clear    (slot_clr),
        .full     (aw_full),
        .q        (aw_q)
    );

    axi_leg_hold_slot #(.W(DATA_W)) u_w_slot (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .in_valid (wvalid),
        .in_ready (wready),
        .in_data  (wdata),
        .clear    (slot_clr),
        .full     (w_full),
        .q        (w_q)
    );

    assign addr_bad = |aw_q[ADDR_W-1:LEG_ADDR_W];

    // State, phase counter and registered legacy strobes/pulses; reset drops the cycle immediately
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            cs_n                 <= 1'b1;
            wr_n                 <= 1'b1;
            transaction_complete <= 1'b0;
            error_detected       <= 1'b0;
        end else begin
            state                <= state_nxt;
            cnt                  <= cnt_nxt;
            cs_n                 <= cs_n_nxt;
            wr_n                 <= wr_n_nxt;
            transaction_complete <= (state_nxt == ST_DONE);
            error_detected       <= err_nxt;
        end
    end

    // Legacy address/data latch; held through the cycle and kept afterwards
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            leg_addr <= '0;
            leg_data <= '0;
        end else if (load) begin
            leg_addr <= aw_q[LEG_ADDR_W-1:0];
            leg_data <= w_q;
        end
    end

    // Next-state: each phase counts down from its length-1 and advances at zero
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        slot_clr  = 1'b0;
        load      = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (aw_full && w_full) begin
                    if (addr_bad) begin
                        slot_clr = 1'b1;
                        err_nxt  = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = ST_SETUP;
                        cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = CNT_W'(PULSE_CYC - 1);
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
`ifdef LEGACY_ACK_TIMEOUT_EN
                    state_nxt = ST_WAIT_ACK;
                    cnt_nxt   = CNT_W'(TIMEOUT_CYC - 1);
`else
                    state_nxt = ST_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
`endif
                end
            end
`ifdef LEGACY_ACK_TIMEOUT_EN
            ST_WAIT_ACK: begin
                if (!leg_ack_n) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    slot_clr  = 1'b1;
                    err_nxt   = 1'b1;
                end
            end
`endif
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                slot_clr  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so the legacy pins come straight from flops
        cs_n_nxt = !(state_nxt == ST_SETUP || state_nxt == ST_PULSE ||
`ifdef LEGACY_ACK_TIMEOUT_EN
                     state_nxt == ST_WAIT_ACK ||
`endif
                     state_nxt == ST_HOLD);
        wr_n_nxt = !(state_nxt == ST_PULSE
`ifdef LEGACY_ACK_TIMEOUT_EN
                     || state_nxt == ST_WAIT_ACK
`endif
                     );
    end

endmodule

// File: tb/tb_axi_wr_to_legacy_bridge.sv
// tb/tb_axi_wr_to_legacy_bridge.sv - scoreboard bench for axi_wr_to_legacy_bridge
module tb_axi_wr_to_legacy_bridge;

    localparam int S = 2;
    localparam int P = 4;
    localparam int H = 1;
    localparam int T = 64;
`ifdef LEGACY_ACK_TIMEOUT_EN
    localparam int ACK_EXTRA = 1;
`else
    localparam int ACK_EXTRA = 0;
`endif
    localparam int LAT_OK  = 1 + S + P + H + ACK_EXTRA;
    localparam int LAT_ERR = 1;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] awaddr = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] wdata = '0;
    logic [15:0] leg_addr;
    logic [31:0] leg_data;
    logic        cs_n;
    logic        wr_n;
    logic        leg_ack_n = 1'b1;
    logic        transaction_complete;
    logic        error_detected;

    axi_wr_to_legacy_bridge #(
        .ADDR_W(32), .DATA_W(32), .LEG_ADDR_W(16),
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .TIMEOUT_CYC(T)
    ) dut (
        .clk_sys              (clk_sys),
        .rst_n                (rst_n),
        .awvalid              (awvalid),
        .awready              (awready),
        .awaddr               (awaddr),
        .wvalid               (wvalid),
        .wready               (wready),
        .wdata                (wdata),
        .leg_addr             (leg_addr),
        .leg_data             (leg_data),
        .cs_n                 (cs_n),
        .wr_n                 (wr_n),
        .leg_ack_n            (leg_ack_n),
        .transaction_complete (transaction_complete),
        .error_detected       (error_detected)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

`ifdef LEGACY_ACK_TIMEOUT_EN
    always @(negedge clk_sys) leg_ack_n = 1'b0;
`else
    always @(negedge clk_sys) leg_ack_n = 1'($urandom);
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the bridge reports an outcome
    int   cs_run = 0;
    int   wr_run = 0;
    bit   cs_prev = 0;
    bit   wr_prev = 0;
    bit   cs_seen = 0;
    exp_t e_mon;
    always @(negedge clk_sys) begin
        if (!rst_n) begin
            cs_run = 0; wr_run = 0; cs_prev = 0; wr_prev = 0; cs_seen = 0;
        end else begin
            if (!cs_n) begin
                if (!cs_prev) cs_run = 0;
                cs_run++;
                cs_seen = 1;
            end
            cs_prev = !cs_n;
            if (!wr_n) begin
                if (!wr_prev) wr_run = 0;
                wr_run++;
            end
            wr_prev = !wr_n;
            if (transaction_complete || error_detected) begin
                chk("pulse_exclusive", 64'(transaction_complete && error_detected), 64'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: complete=%0b error=%0b with nothing outstanding (cycle %0d)",
                             transaction_complete, error_detected, cyc);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("outcome_is_error", 64'(error_detected), 64'(e_mon.is_err));
                    chk("outcome_cycle", 64'(cyc), 64'(e_mon.cyc));
                    if (e_mon.is_err) begin
                        chk("err_no_cs_activity", 64'(cs_seen), 64'd0);
                        chk("err_ready_back", 64'({awready, wready}), 64'b11);
                    end else begin
                        chk("leg_addr", 64'(leg_addr), 64'(e_mon.addr));
                        chk("leg_data", 64'(leg_data), 64'(e_mon.data));
                        chk("cs_low_cycles", 64'(cs_run), 64'(S + P + H + ACK_EXTRA));
                        chk("wr_low_cycles", 64'(wr_run), 64'(P + ACK_EXTRA));
                        chk("ready_held_in_done", 64'({awready, wready}), 64'b00);
                    end
                end
                cs_seen = 0;
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input int dly, output int cap);
        bit hs;
        hs  = 0;
        cap = -1;
        repeat (dly) @(negedge clk_sys);
        awvalid = 1'b1;
        awaddr  = a;
        for (int n = 0; n < 300; n++) begin
            hs = awready;
            @(negedge clk_sys);
            if (hs) break;
        end
        awvalid = 1'b0;
        awaddr  = $urandom;
        if (hs) cap = cyc;
        else begin
            n_cmp++; n_bad++;
            $display("FAIL aw_handshake: no awready within bound, expected acceptance");
        end
    endtask

    task automatic send_w(input logic [31:0] d, input int dly, output int cap);
        bit hs;
        hs  = 0;
        cap = -1;
        repeat (dly) @(negedge clk_sys);
        wvalid = 1'b1;
        wdata  = d;
        for (int n = 0; n < 300; n++) begin
            hs = wready;
            @(negedge clk_sys);
            if (hs) break;
        end
        wvalid = 1'b0;
        wdata  = $urandom;
        if (hs) cap = cyc;
        else begin
            n_cmp++; n_bad++;
            $display("FAIL w_handshake: no wready within bound, expected acceptance");
        end
    endtask

    // Issue one write; the reference outcome follows from the address range and the fixed phase lengths
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input int ad, input int wd, input bit track);
        int   ca, cw, full_cyc;
        exp_t e;
        fork
            send_aw(a, ad, ca);
            send_w(d, wd, cw);
        join
        if (track && ca >= 0 && cw >= 0) begin
            full_cyc = (ca > cw) ? ca : cw;
            e.is_err = (a[31:16] != 16'h0);
            e.cyc    = full_cyc + (e.is_err ? LAT_ERR : LAT_OK);
            e.addr   = a[15:0];
            e.data   = d;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        logic [31:0] a;
        bit          bad;

        @(negedge clk_sys);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd1);
        chk("rst_cs_n", 64'(cs_n), 64'd1);
        chk("rst_wr_n", 64'(wr_n), 64'd1);
        chk("rst_leg_addr", 64'(leg_addr), 64'd0);
        chk("rst_leg_data", 64'(leg_data), 64'd0);
        chk("rst_pulses", 64'({transaction_complete, error_detected}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        issue(32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 1);
        issue(32'h0000_0010, 32'h0000_1234, 5, 0, 1);
        issue(32'h0001_0000, 32'h5555_AAAA, 0, 0, 1);
        issue(32'h0000_00A0, 32'h1111_2222, 0, 0, 1);
        issue(32'h0000_00A4, 32'h3333_4444, 0, 0, 1);
        issue(32'h0000_FFFF, 32'hFFFF_FFFF, 0, 3, 1);
        issue(32'hFFFF_0000, 32'h0000_0001, 2, 0, 1);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk_sys);

        issue(32'h0000_0123, 32'hCAFE_F00D, 0, 0, 0);
        for (int i = 0; i < 50 && wr_n; i++) @(negedge clk_sys);
        chk("reached_pulse_phase", 64'(wr_n), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cs_n", 64'(cs_n), 64'd1);
        chk("async_rst_wr_n", 64'(wr_n), 64'd1);
        @(negedge clk_sys);
        chk("rst_mid_pulses", 64'({transaction_complete, error_detected}), 64'd0);
        chk("rst_mid_leg_addr", 64'(leg_addr), 64'd0);
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        chk("post_rst_ready", 64'({awready, wready}), 64'b11);

        issue(32'h0000_0200, 32'h0BAD_F00D, 0, 0, 1);
        for (int k = 0; k < 24; k++) begin
            bad = ($urandom_range(0, 4) == 0);
            a   = bad ? {16'($urandom_range(1, 16'hFFFF)), 16'($urandom)} : {16'h0, 16'($urandom)};
            issue(a, $urandom, $urandom_range(0, 6), $urandom_range(0, 6), 1);
        end

        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk_sys);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (5) @(negedge clk_sys);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
